// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, FSM state encoding and opcode classification.
// ALU_MC_DIV_EN makes code 100 an iterative divide instead of an illegal code.
package alu_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_DIV = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;
  function automatic logic is_iter(input logic [2:0] op);
`ifdef ALU_MC_DIV_EN
    return op == ALU_MUL || op == ALU_DIV;
`else
    return op == ALU_MUL;
`endif
  endfunction
  function automatic logic is_single(input logic [2:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
  endfunction
endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: radix-2 shift-add multiplier and, with ALU_MC_DIV_EN, restoring divider.
// result_o presents the value produced by the iteration completing on this edge.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
`ifdef ALU_MC_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             last_o
);
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef ALU_MC_DIV_EN
  // opa holds the divisor, opb the dividend shifting out / quotient shifting in
  logic             div_q, div_d;
  logic [WIDTH:0]   rem_sh, diff;
`endif

  always_comb begin
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
`ifdef ALU_MC_DIV_EN
    div_d  = div_q;
    rem_sh = {acc_q, opb_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opa_q};
`endif
    if (start_i) begin
      acc_d = '0;
      cnt_d = CNT_W'(WIDTH);
`ifdef ALU_MC_DIV_EN
      div_d = div_i;
      opa_d = div_i ? b_i : a_i;
      opb_d = div_i ? a_i : b_i;
`else
      opa_d = a_i;
      opb_d = b_i;
`endif
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      acc_d = acc_q + (opb_q[0] ? opa_q : '0);
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
`ifdef ALU_MC_DIV_EN
      if (div_q) begin
        acc_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        opa_d = opa_q;
        opb_d = {opb_q[WIDTH-2:0], ~diff[WIDTH]};
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
`ifdef ALU_MC_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
`ifdef ALU_MC_DIV_EN
      div_q <= div_d;
`endif
    end
  end

`ifdef ALU_MC_DIV_EN
  assign result_o = div_q ? opb_d : acc_d;
`else
  assign result_o = acc_d;
`endif
  assign last_o = cnt_q == CNT_W'(1);
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked multi-cycle ALU with registered result and flags.
// ALU_MC_DIV_EN enables the iterative unsigned divide on code 100.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             Ovf_o,
  output logic             Illegal_o
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;
  logic             accept, start, slt, ovf_c, iter_last;
  logic [WIDTH-1:0] sum, dif, alu_res, iter_res;

  alu_iter_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (start),
`ifdef ALU_MC_DIV_EN
    .div_i    (ALUCtrl_i == ALU_DIV),
`endif
    .a_i      (data1_i),
    .b_i      (data2_i),
    .result_o (iter_res),
    .last_o   (iter_last)
  );

  always_comb begin
    accept  = valid_i && state_q == IDLE;
    start   = accept && is_iter(ALUCtrl_i);
    sum     = data1_i + data2_i;
    dif     = data1_i - data2_i;
    slt     = $signed(data1_i) < $signed(data2_i);
    alu_res = ALUCtrl_i == ALU_AND ? data1_i & data2_i :
              ALUCtrl_i == ALU_OR  ? data1_i | data2_i :
              ALUCtrl_i == ALU_ADD ? sum :
              ALUCtrl_i == ALU_SUB ? dif :
              ALUCtrl_i == ALU_SLT ? WIDTH'(slt) : '0;
    ovf_c   = ALUCtrl_i == ALU_ADD ? data1_i[WIDTH-1] == data2_i[WIDTH-1] && sum[WIDTH-1] != data1_i[WIDTH-1] :
              ALUCtrl_i == ALU_SUB ? data1_i[WIDTH-1] != data2_i[WIDTH-1] && dif[WIDTH-1] != data1_i[WIDTH-1] :
              1'b0;
    state_d = state_q;
    data_d  = data_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    if (start) begin
      state_d = BUSY;
    end else if (accept) begin
      state_d = DONE;
      data_d  = alu_res;
      zero_d  = alu_res == '0;
      ovf_d   = ovf_c;
      ill_d   = !is_single(ALUCtrl_i);
    end else if (state_q == BUSY && iter_last) begin
      state_d = DONE;
      data_d  = iter_res;
      zero_d  = iter_res == '0;
      ovf_d   = 1'b0;
      ill_d   = 1'b0;
    end else if (state_q == DONE && ready_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  assign ready_o   = state_q == IDLE;
  assign valid_o   = state_q == DONE;
  assign data_o    = data_q;
  assign Zero_o    = zero_q;
  assign Ovf_o     = ovf_q;
  assign Illegal_o = ill_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and random checks of alu_multicycle against an arithmetic model.
module tb_alu_multicycle;
  localparam int W = 32;
  logic         clk = 1'b0, rst_n, valid_i = 1'b0, ready_i = 1'b1;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         ready_o, valid_o, zero_o, ovf_o, ill_o;
  logic [W-1:0] data_o;
  int           total = 0, bad = 0;
  int           m_cnt = 0, accepted = 0, issued = 0;
  bit           m_res = 0, m_ovf = 0, m_ill = 0;
  logic [W-1:0] m_data = '0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .ALUCtrl_i(op), .data1_i(a), .data2_i(b), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .Zero_o(zero_o), .Ovf_o(ovf_o), .Illegal_o(ill_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] d, output logic ov, output logic il, output int lat);
    longint s;
    d = '0; ov = 0; il = 0; lat = 1; s = 0;
    case (o)
      3'b000: d = x & y;
      3'b001: d = x | y;
      3'b010: begin s = longint'($signed(x)) + longint'($signed(y)); d = W'(s); ov = s != longint'($signed(d)); end
      3'b110: begin s = longint'($signed(x)) - longint'($signed(y)); d = W'(s); ov = s != longint'($signed(d)); end
      3'b111: d = ($signed(x) < $signed(y)) ? 1 : 0;
      3'b011: begin s = longint'({32'b0, x}) * longint'({32'b0, y}); d = W'(s); lat = W + 1; end
`ifdef ALU_MC_DIV_EN
      3'b100: begin d = (y == 0) ? '1 : x / y; lat = W + 1; end
`endif
      default: il = 1;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] d;
    logic ov, il;
    int lat;
    if (!rst_n) begin
      m_cnt = 0; m_res = 0;
    end else if (m_res) begin
      if (ready_i) m_res = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_res = 1;
    end else if (valid_i) begin
      model(op, a, b, d, ov, il, lat);
      m_data = d; m_ovf = ov; m_ill = il;
      accepted++;
      m_cnt = lat - 1;
      m_res = lat == 1;
    end
  end

  always @(negedge clk) begin
    chk("ready", ready_o, !m_res && m_cnt == 0);
    chk("valid", valid_o, m_res);
    if (m_res) begin
      chk("data", data_o, m_data);
      chk("zero", zero_o, m_data == 0);
      chk("ovf", ovf_o, m_ovf);
      chk("illegal", ill_o, m_ill);
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] e_d, input logic e_ovf, input logic e_zero,
                        input logic e_ill, input int e_lat);
    int n = 0, lat;
    while (!ready_o && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("idle_wait", ready_o, 1);
    @(negedge clk);
    op = o; a = x; b = y; valid_i = 1; issued++;
    @(posedge clk); #1;
    valid_i = 0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    lat = 1;
    while (!valid_o && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("lat", lat, e_lat);
    chk("lit_data", data_o, e_d);
    chk("lit_ovf", ovf_o, e_ovf);
    chk("lit_zero", zero_o, e_zero);
    chk("lit_ill", ill_o, e_ill);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_zero", zero_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_ill", ill_o, 0);
    run_op(3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0, 0, 1);
    run_op(3'b010, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1, 0, 1);
    run_op(3'b110, 32'd5, 32'd5, 32'h0, 0, 1, 0, 1);
    run_op(3'b110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 0, 0, 1);
    run_op(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 0, 1);
    run_op(3'b111, 32'h1, 32'hFFFF_FFFF, 32'h0, 0, 1, 0, 1);
    run_op(3'b011, 32'h0001_0003, 32'h7, 32'h0007_0015, 0, 0, 0, 33);
    run_op(3'b101, 32'h1234, 32'h5678, 32'h0, 0, 1, 1, 1);
`ifdef ALU_MC_DIV_EN
    run_op(3'b100, 32'd100, 32'd7, 32'd14, 0, 0, 0, 33);
    run_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, 33);
`else
    run_op(3'b100, 32'd100, 32'd7, 32'h0, 0, 1, 1, 1);
`endif
    run_op(3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 0, 0, 1);
    ready_i = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_data", data_o, 32'h0000_F000);
    chk("stall_valid", valid_o, 1);
    chk("stall_ready", ready_o, 0);
    @(negedge clk);
    ready_i = 1;
    @(posedge clk); #1;
    @(negedge clk);
    op = 3'b011; a = $urandom; b = $urandom; valid_i = 1; issued++;
    @(posedge clk);
    @(negedge clk);
    valid_i = 0;
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_ready", ready_o, 1);
    chk("abort_valid", valid_o, 0);
    @(negedge clk);
    rst_n = 1;
    n = 0;
    repeat (40) begin @(posedge clk); #1; if (valid_o) n++; end
    chk("abort_no_valid", n, 0);
    repeat (8000) begin
      @(negedge clk);
      ready_i = $urandom_range(0, 3) != 0;
      if (valid_i && accepted == issued) valid_i = 0;
      if (!valid_i) begin
        op = 3'($urandom_range(0, 7));
        a = pick();
        b = pick();
        if (issued < 220 && $urandom_range(0, 2) == 0) begin
          valid_i = 1;
          issued++;
        end
      end
    end
    n = 0;
    while (n < 300 && (valid_i || m_res || m_cnt != 0)) begin
      @(negedge clk);
      ready_i = 1;
      if (valid_i && accepted == issued) valid_i = 0;
      n++;
    end
    chk("drain", n < 300, 1);
    chk("accepted_all", accepted, issued);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, handshaked ALU for the multi-cycle CPU datapath, succeeding the single-cycle combinational ALU. It keeps the existing 3-bit ALU control encoding and adds registered results, a valid/ready handshake, an iterative shift-add multiplier and a true set-less-than. An optional iterative unsigned divider is available as a compile-time option. It sits between the ALU control decoder and the EX/MEM result register.

## Interface
- WIDTH, 32: operand and result width in bits. Must be at least 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; do not override.

- clk_i  in  1: the single clock.
- rst_n_i  in  1: asynchronous, active-low reset.
- valid_i  in  1: the operation request is valid.
- ready_o  out  1: the block can accept a request.
- ALUCtrl_i  in  3: operation code.
- data1_i  in  WIDTH: operand A.
- data2_i  in  WIDTH: operand B.
- valid_o  out  1: the result is valid.
- ready_i  in  1: the downstream stage takes the result.
- data_o  out  WIDTH: the result.
- Zero_o  out  1: high when data_o is 0.
- Ovf_o  out  1: signed overflow on ADD or SUB. 0 for all other operations.
- Illegal_o  out  1: the operation code is unsupported.

## Operation
- Encoding:
  - 000 AND, 001 OR, 010 ADD, 110 SUB.
  - 111 SLT: signed comparison; result is 1 if A<B, else 0.
  - 011 MUL: low WIDTH bits of A*B.
  - 100 DIV: only with the macro enabled.
  - Any other code is illegal.
- Transfer rules:
  - A request is accepted on a clock edge where valid_i && ready_o.
  - Operands and ALUCtrl_i are captured at acceptance. Later changes to the inputs are ignored.
- State machine, states IDLE, BUSY, DONE:
  - IDLE: ready_o is 1.
    - On accepting a single-cycle op (AND, OR, ADD, SUB, SLT) or an illegal code: compute, register the result, go to DONE.
    - On accepting MUL or DIV: load the counter with WIDTH, clear the accumulator, go to BUSY.
  - BUSY: ready_o is 0.
    - One radix-2 iteration per cycle; the counter decrements.
    - When the counter reaches 1, the final iteration completes and the state goes to DONE.
  - DONE: valid_o is 1 and outputs are held stable.
    - If ready_i is high, go to IDLE on that edge.
    - There is no back-to-back acceptance in DONE; ready_o is 0.
- MUL: unsigned shift-add. The low WIDTH bits are identical for signed operands.
- Flags:
  - Zero_o is registered with data_o and is valid only while valid_o is 1.
  - Ovf_o for ADD: the operands have equal signs and the result sign differs.
  - Ovf_o for SUB: the operands have opposite signs and the result sign differs from A.
- Illegal code: data_o=0, Zero_o=1, Ovf_o=0, Illegal_o=1. Illegal_o is 0 for all legal operations.

## Timing
- Reset values:
  - state=IDLE.
  - ready_o=1 (from IDLE).
  - valid_o=0, data_o=0, Zero_o=0, Ovf_o=0, Illegal_o=0.
  - Counter and accumulator cleared.
- Reset asserted mid-operation aborts immediately. There is no pending result after release.
- Latency is counted from the acceptance edge to the edge where valid_o is seen high:
  - Single-cycle ops and illegal codes: 1 cycle.
  - MUL and DIV: WIDTH+1 cycles.
- Throughput with ready_i tied high: one op per 2 cycles for single-cycle ops, and one per WIDTH+2 cycles for MUL.
- ready_i low in DONE stalls indefinitely with no change to any output.
- ready_i is ignored outside DONE.
- valid_i while the block is busy is not accepted. The requester must hold the request until ready_o.

## Configuration
- ALU_MC_DIV_EN defined:
  - Code 100 performs an unsigned restoring divide, data_o = A/B, in WIDTH iterations.
  - Divide by zero gives data_o = all ones and Illegal_o=0.
- ALU_MC_DIV_EN undefined:
  - Code 100 is illegal: 1-cycle latency, Illegal_o=1.
  - No divider logic is synthesised.

## Structure
- Shared package alu_pkg:
  - Opcode localparams ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL, ALU_DIV.
  - State encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - The CPU control decoder imports the same package.
- The iteration datapath goes in one sub-module, alu_iter_unit. It holds the accumulator, shifted operands and counter, and performs MUL and, under the macro, DIV. The top holds the FSM, the single-cycle logic and the output registers.

## Test plan
Settings: WIDTH=32, ready_i=1 unless stated.

- Reset, then no stimulus: ready_o=1, valid_o=0, data_o=0, Zero_o=0, Illegal_o=0.
- ADD 0x7FFFFFFF+1: data_o=0x80000000, Ovf_o=1, Zero_o=0 after 1 cycle.
- SUB 5-5: data_o=0, Zero_o=1.
- SLT of -1 (0xFFFFFFFF) vs 1: data_o=1.
- MUL 0x0001_0003 * 0x0000_0007: data_o=0x0007_0015, valid_o after 33 cycles, ready_o=0 throughout.
- Code 101: Illegal_o=1, data_o=0, Zero_o=1.
- DIV 100/7 with the macro on: data_o=14 after 33 cycles. DIV by 0: data_o=0xFFFFFFFF. With the macro off, code 100 is illegal.
- Hold ready_i=0 for 5 cycles after a result: outputs are stable and ready_o=0.
- Assert rst_n_i at MUL iteration 10: valid_o=0, ready_o=1 immediately after reset, and no later valid_o.
